// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers, AES column/state types and transform mode for the MixColumns engine.
package aes_gf_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned NUM_COLS = 4;

    // Low byte of the AES reduction polynomial x^8+x^4+x^3+x+1.
    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1b;

    typedef logic [COL_W-1:0]   aes_col_t;
    typedef logic [STATE_W-1:0] aes_state_t;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } aes_mode_e;

    // Multiply by x modulo the AES polynomial.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul2(input logic [BYTE_W-1:0] b);
        return xtime(b);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul3(input logic [BYTE_W-1:0] b);
        return xtime(b) ^ b;
    endfunction

    // 9 = 8 + 1
    function automatic logic [BYTE_W-1:0] gf_mul9(input logic [BYTE_W-1:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    // 11 = 8 + 2 + 1
    function automatic logic [BYTE_W-1:0] gf_mulb(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x2;
        x2 = xtime(b);
        return xtime(xtime(x2)) ^ x2 ^ b;
    endfunction

    // 13 = 8 + 4 + 1
    function automatic logic [BYTE_W-1:0] gf_muld(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x4;
        x4 = xtime(xtime(b));
        return xtime(x4) ^ x4 ^ b;
    endfunction

    // 14 = 8 + 4 + 2
    function automatic logic [BYTE_W-1:0] gf_mule(input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        x2 = xtime(b);
        x4 = xtime(x2);
        return xtime(x4) ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_mix_column_unit.sv
// Combinational MixColumns / InvMixColumns transform of a single 32-bit column.
module aes_mix_column_unit
    import aes_gf_pkg::*;
(
    input  aes_mode_e mode,
    input  aes_col_t  col_in,
    output aes_col_t  col_out_c
);

    logic [7:0] a0, a1, a2, a3;
    aes_col_t   fwd_col;
    aes_col_t   inv_col;

    // Byte r of the column sits at bits [31-8r -: 8].
    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Forward matrix rows [02 03 01 01] rotated per row.
    always_comb begin
        fwd_col        = '0;
        fwd_col[31:24] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
        fwd_col[23:16] = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
        fwd_col[15:8]  = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
        fwd_col[7:0]   = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);
    end

    // Inverse matrix rows [0e 0b 0d 09] rotated per row.
    always_comb begin
        inv_col        = '0;
        inv_col[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
        inv_col[23:16] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
        inv_col[15:8]  = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
        inv_col[7:0]   = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
    end

    assign col_out_c = (mode == MODE_INV) ? inv_col : fwd_col;

endmodule

// File: rtl/aes_mix_columns_engine.sv
// Handshaked MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per clock.
module aes_mix_columns_engine
    import aes_gf_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int unsigned NUM_STEPS = NUM_COLS / COLS_PER_CYCLE;
    localparam int unsigned CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Reject unsupported column widths at elaboration.
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("aes_mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]                   state;
    logic [1:0]                   state_nxt;
    logic                         load_in;
    logic                         step;
    logic                         last_step;
    logic [CNT_W-1:0]             cnt;
    aes_mode_e                    mode_q;
    aes_col_t [NUM_COLS-1:0]      work;
    aes_col_t [NUM_COLS-1:0]      work_nxt;
    logic [1:0]                   col_base;
    logic [1:0]                   unit_sel [COLS_PER_CYCLE];
    aes_col_t                     unit_in  [COLS_PER_CYCLE];
    aes_col_t                     unit_out [COLS_PER_CYCLE];

    assign last_step = (cnt == CNT_W'(NUM_STEPS - 1));
    assign col_base  = 2'(32'(cnt) * COLS_PER_CYCLE);

    // Column c lives at packed index 3-c of the working register.
    generate
        for (genvar g = 0; g < int'(COLS_PER_CYCLE); g++) begin : g_unit
            assign unit_sel[g] = 2'(NUM_COLS - 1) - (col_base + 2'(g));
            assign unit_in[g]  = work[unit_sel[g]];

            aes_mix_column_unit u_col (
                .mode      (mode_q),
                .col_in    (unit_in[g]),
                .col_out_c (unit_out[g])
            );
        end
    endgenerate

    // Splice this step's transformed columns back into the working state.
    always_comb begin
        work_nxt = work;
        for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
            work_nxt[unit_sel[g]] = unit_out[g];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and datapath enables.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load_in   = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_in   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load_in   = 1'b1;
                        state_nxt = ST_BUSY;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working state, latched mode, step counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            mode_q    <= MODE_FWD;
            cnt       <= '0;
            out_state <= '0;
        end else if (load_in) begin
            work   <= in_state;
            mode_q <= aes_mode_e'(in_mode);
            cnt    <= '0;
        end else if (step) begin
            work <= work_nxt;
            if (last_step) begin
                cnt       <= '0;
                out_state <= work_nxt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
